// File: rtl/mi_arbiter_if.sv
// Memory-interface bus between the arbiter (master) and qpi_memctrl (slave).
interface mi_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 7
);
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic          rw;
  logic          valid;
  logic          ready;
  logic [31:0]   wdata;
  logic          wack;
  logic          wlast;
  logic [31:0]   rdata;
  logic          rstb;
  logic          rlast;

  modport master (
    output addr, len, rw, valid, wdata,
    input  ready, wack, wlast, rdata, rstb, rlast
  );

  modport slave (
    input  addr, len, rw, valid, wdata,
    output ready, wack, wlast, rdata, rstb, rlast
  );
endinterface

// File: rtl/mi_arbiter.sv
// Round-robin arbiter sharing one mi_* memory interface between N requesters, grant held per burst.
// Define MI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer register).
module mi_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*AW-1:0] u_addr,
  input  logic [N*LW-1:0] u_len,
  input  logic [N-1:0]    u_rw,
  input  logic [N-1:0]    u_valid,
  output logic [N-1:0]    u_ready,
  input  logic [N*32-1:0] u_wdata,
  output logic [N-1:0]    u_wack,
  output logic [N-1:0]    u_wlast,
  output logic [31:0]     u_rdata,
  output logic [N-1:0]    u_rstb,
  output logic [N-1:0]    u_rlast,
  mi_arbiter_if.master    mi,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e        state_q;
  logic [N-1:0]  grant_q;
  logic [IW-1:0] owner_q;
  logic          dir_q;
  logic          busy_q;

  logic [IW-1:0] ptr;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;
  logic          pick_any;
  logic          own_valid, own_rw;
  logic          wr_end, rd_end, cmd_end, data_end, hs;

  // First valid requester at or after the pointer, wrapping modulo N.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (!pick_any && u_valid[(int'(ptr) + k) % int'(N)]) begin
        pick_any = 1'b1;
        pick_idx = IW'((int'(ptr) + k) % int'(N));
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = pick_any;
  end

  assign own_valid = u_valid[owner_q];
  assign own_rw    = u_rw[owner_q];
  assign wr_end    = mi.wack & mi.wlast;
  assign rd_end    = mi.rstb & mi.rlast;
  assign cmd_end   = own_rw ? rd_end : wr_end;
  assign data_end  = dir_q ? rd_end : wr_end;
  assign hs        = (state_q == StCmd) & own_valid & mi.ready;

`ifdef MI_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] ptr_q;

  // The completing owner drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  assign ptr = ptr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            state_q <= StCmd;
            grant_q <= pick_oh;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
          end
        end
        StCmd: begin
          if (!own_valid) begin
            state_q <= StIdle;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (mi.ready) begin
            dir_q <= own_rw;
            // Single-beat transfers may finish in the handshake cycle.
            if (cmd_end) begin
              state_q <= StIdle;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (data_end) begin
            state_q <= StIdle;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mi.addr  = u_addr[AW*owner_q +: AW];
  assign mi.len   = u_len[LW*owner_q +: LW];
  assign mi.rw    = own_rw;
  assign mi.wdata = u_wdata[32*owner_q +: 32];
  assign mi.valid = (state_q == StCmd) & own_valid;

  // grant_q is zero when idle, so gating with it keeps non-owners quiet in every state.
  assign u_ready = (state_q == StCmd) ? (grant_q & {N{mi.ready}}) : '0;
  assign u_wack  = grant_q & {N{mi.wack}};
  assign u_wlast = grant_q & {N{mi.wlast}};
  assign u_rstb  = grant_q & {N{mi.rstb}};
  assign u_rlast = grant_q & {N{mi.rlast}};
  assign u_rdata = mi.rdata;

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mi_arbiter.sv
// Directed plus randomized bench for mi_arbiter; the bench plays the requesters and the controller.
module tb_mi_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] u_addr;
  logic [N*LW-1:0] u_len;
  logic [N-1:0]    u_rw;
  logic [N-1:0]    u_valid;
  logic [N-1:0]    u_ready;
  logic [N*32-1:0] u_wdata;
  logic [N-1:0]    u_wack, u_wlast, u_rstb, u_rlast;
  logic [31:0]     u_rdata;
  logic [N-1:0]    grant;
  logic            busy;

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;

  mi_arbiter_if #(.AW(AW), .LW(LW)) mi ();

  mi_arbiter #(.N(N), .AW(AW), .LW(LW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .u_addr  (u_addr),
    .u_len   (u_len),
    .u_rw    (u_rw),
    .u_valid (u_valid),
    .u_ready (u_ready),
    .u_wdata (u_wdata),
    .u_wack  (u_wack),
    .u_wlast (u_wlast),
    .u_rdata (u_rdata),
    .u_rstb  (u_rstb),
    .u_rlast (u_rlast),
    .mi      (mi.master),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference rule: first valid at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int next_ptr(input int owner);
`ifdef MI_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (owner + 1) % N;
`endif
  endfunction

  task automatic set_req(input int i, input logic rw, input int len);
    u_addr[i*AW +: AW]  = $urandom;
    u_len[i*LW +: LW]   = LW'(len);
    u_rw[i]             = rw;
    u_wdata[i*32 +: 32] = $urandom;
  endtask

  task automatic clear_beats;
    mi.wack  = 1'b0;
    mi.wlast = 1'b0;
    mi.rstb  = 1'b0;
    mi.rlast = 1'b0;
  endtask

  // One complete transfer, started from IDLE with u_valid already driven.
  task automatic xfer(input bit keep, input logic [N-1:0] raise, input int rdly,
                      input bit stray, output int eo);
    int          nb;
    logic        rw;
    logic [63:0] oh;
    logic [31:0] rd;
    eo = pick(u_valid, ptr_m);
    if (eo < 0) begin
      check("xfer_no_requester", 64'(0), 64'(1));
      return;
    end
    oh = 64'(1) << eo;
    rw = u_rw[eo];
    nb = int'(u_len[eo*LW +: LW]) + 1;
    tick;
    check("cmd_grant", grant, oh);
    check("cmd_busy", busy, 1);
    check("cmd_mi_valid", mi.valid, 1);
    check("cmd_mi_addr", mi.addr, u_addr[eo*AW +: AW]);
    check("cmd_mi_len", mi.len, u_len[eo*LW +: LW]);
    check("cmd_mi_rw", mi.rw, rw);
    for (int d = 0; d < rdly; d++) begin
      check("cmd_wait_ready", u_ready, 0);
      tick;
      check("cmd_wait_grant", grant, oh);
    end
    mi.ready = 1'b1;
    #1;
    check("cmd_u_ready", u_ready, oh);
    tick;
    mi.ready = 1'b0;
    if (!keep) u_valid[eo] = 1'b0;
    u_valid = u_valid | raise;
    ptr_m = next_ptr(eo);
    if (stray) begin
      if (rw) begin mi.wack = 1'b1; mi.wlast = 1'b1; end
      else begin mi.rstb = 1'b1; mi.rlast = 1'b1; end
      #1;
      check("stray_forward", rw ? u_wlast : u_rlast, oh);
      tick;
      clear_beats();
      check("stray_hold_grant", grant, oh);
    end
    for (int b = 0; b < nb; b++) begin
      if (rw) begin
        rd = $urandom;
        mi.rdata = rd;
        mi.rstb  = 1'b1;
        mi.rlast = (b == nb - 1);
        #1;
        check("rd_rstb", u_rstb, oh);
        check("rd_rlast", u_rlast, (b == nb - 1) ? oh : 64'(0));
        check("rd_rdata", u_rdata, rd);
      end else begin
        u_wdata[eo*32 +: 32] = $urandom;
        mi.wack  = 1'b1;
        mi.wlast = (b == nb - 1);
        #1;
        check("wr_wdata", mi.wdata, u_wdata[eo*32 +: 32]);
        check("wr_wack", u_wack, oh);
        check("wr_wlast", u_wlast, (b == nb - 1) ? oh : 64'(0));
      end
      tick;
      clear_beats();
      if (b < nb - 1) begin
        check("data_hold_grant", grant, oh);
        check("data_mi_valid", mi.valid, 0);
        if ($urandom_range(0, 3) == 0) tick;
      end
    end
    check("end_grant", grant, 0);
    check("end_busy", busy, 0);
  endtask

  initial begin
    int eo;
    int exp3 [4];
    rst_n    = 1'b0;
    u_addr   = '0;
    u_len    = '0;
    u_rw     = '0;
    u_valid  = '0;
    u_wdata  = '0;
    mi.ready = 1'b0;
    mi.rdata = '0;
    clear_beats();
    tick;
    tick;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_mi_valid", mi.valid, 0);
    check("rst_u_ready", u_ready, 0);
    rst_n = 1'b1;
    tick;

    // Single read, 4 beats.
    set_req(0, 1'b1, 3);
    u_addr[0 +: AW] = 32'h100;
    u_valid = 3'b001;
    xfer(1'b0, '0, 1, 1'b0, eo);
    check("read_owner", eo, 0);

    // Async reset in the middle of a burst.
    set_req(0, 1'b1, 3);
    u_valid = 3'b001;
    tick;
    mi.ready = 1'b1;
    tick;
    mi.ready = 1'b0;
    u_valid  = 3'b000;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_mi_valid", mi.valid, 0);
    tick;
    rst_n = 1'b1;
    ptr_m = 0;
    u_valid = 3'b001;
    tick;
    check("post_rst_grant", grant, 3'b001);
    u_valid = 3'b000;
    tick;
    check("post_rst_abort_idle", grant, 0);

    // Contention with both valids held for four single-beat writes.
`ifdef MI_ARB_FIXED_PRIO_EN
    exp3 = '{0, 0, 0, 0};
`else
    exp3 = '{0, 1, 0, 1};
`endif
    set_req(0, 1'b0, 0);
    set_req(1, 1'b0, 0);
    u_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      xfer(1'b1, '0, 0, 1'b0, eo);
      check("contention_owner", eo, exp3[k]);
    end
    u_valid = 3'b000;

    // Lone top requester brings the pointer back to 0.
    set_req(2, 1'b0, 1);
    u_valid = 3'b100;
    xfer(1'b0, '0, 0, 1'b0, eo);
    check("wrap_owner", eo, 2);

    // Abort in CMD leaves the pointer alone.
    set_req(0, 1'b0, 0);
    u_valid = 3'b001;
    tick;
    check("abort_grant", grant, 3'b001);
    u_valid = 3'b000;
    #1;
    check("abort_mi_valid", mi.valid, 0);
    tick;
    check("abort_idle_grant", grant, 0);
    check("abort_idle_busy", busy, 0);
    set_req(0, 1'b0, 0);
    set_req(1, 1'b1, 0);
    u_valid = 3'b011;
    xfer(1'b0, '0, 0, 1'b0, eo);
    check("after_abort_owner", eo, 0);
    u_valid = 3'b000;

    // No preemption: requester 1 appears during an 8-beat write.
    set_req(0, 1'b0, 7);
    set_req(1, 1'b1, 2);
    u_valid = 3'b001;
    xfer(1'b0, 3'b010, 2, 1'b0, eo);
    check("nopreempt_first", eo, 0);
    xfer(1'b0, '0, 0, 1'b0, eo);
    check("nopreempt_second", eo, 1);

    // Handshake and last write beat in the same cycle.
    set_req(0, 1'b0, 0);
    u_valid = 3'b001;
    eo = pick(u_valid, ptr_m);
    tick;
    check("same_cycle_grant", grant, 64'(1) << eo);
    mi.ready = 1'b1;
    mi.wack  = 1'b1;
    mi.wlast = 1'b1;
    #1;
    check("same_cycle_u_ready", u_ready, 64'(1) << eo);
    check("same_cycle_u_wlast", u_wlast, 64'(1) << eo);
    tick;
    mi.ready = 1'b0;
    clear_beats();
    u_valid = 3'b000;
    ptr_m = next_ptr(eo);
    check("same_cycle_idle_grant", grant, 0);
    check("same_cycle_idle_busy", busy, 0);

    // Randomized traffic against the reference rules.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
      u_valid = N'($urandom_range(1, (1 << N) - 1));
      xfer(1'($urandom_range(0, 1)), N'($urandom_range(0, (1 << N) - 1)),
           $urandom_range(0, 2), 1'($urandom_range(0, 1)), eo);
    end
    u_valid = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
